// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store port: access sizes, response
// error codes, FSM states and the optional unsigned-load extension helper.
package lsu_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_BIT  = 2'b11;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   // Memory returns sign-extended data; this keeps only the accessed bits.
   function automatic logic [31:0] zext_load(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] r;
      r = data;
      case (size)
         SZ_HALF: r = {16'h0, data[15:0]};
         SZ_BYTE: r = {24'h0, data[7:0]};
         SZ_BIT:  r = {31'h0, data[0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Pipeline request/response and data-memory bus of the load/store port.
// Carries req_unsigned only when LSU_UNSIGNED_EN is defined.
// Request handshake: a request is taken at a rising edge where req_valid and
// req_ready are both high; req_ready is high only when the port is idle, the
// response is a single rsp_valid pulse with no backpressure, and a memory
// access completes at an edge where mem_req and mem_ready are both high.
interface lsu_mem_port_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef LSU_UNSIGNED_EN
   logic        req_unsigned;
`endif
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [1:0]  mem_byte_addr;
   logic [1:0]  mem_sel;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      input  req_valid, req_we, req_size, req_addr, req_wdata,
`ifdef LSU_UNSIGNED_EN
      input  req_unsigned,
`endif
      output req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_addr, mem_byte_addr, mem_sel, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      output req_valid, req_we, req_size, req_addr, req_wdata,
`ifdef LSU_UNSIGNED_EN
      output req_unsigned,
`endif
      input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_addr, mem_byte_addr, mem_sel, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/lsu_align_check.sv
// Alignment check for a MIPS load/store: words need addr[1:0]==0, halves
// need addr[0]==0, byte and bit accesses are always aligned.
module lsu_align_check
   import lsu_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic       misaligned
);

   always_comb begin
      misaligned = 1'b0;
      case (size)
         SZ_WORD: misaligned = |addr_lo;
         SZ_HALF: misaligned = addr_lo[0];
         default: misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator: one access at a time, alignment check,
// memory wait with optional timeout. Optional unsigned loads: LSU_UNSIGNED_EN.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic          clk,
   input  logic          rst_n,
   lsu_mem_port_if.master bus,
   output lsu_state_e    state_dbg
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             misaligned;
   logic             accept, mem_done, timed_out;
   logic             mem_req_q, mem_we_q;
   logic [29:0]      mem_addr_q;
   logic [1:0]       mem_byte_addr_q, mem_sel_q;
   logic [31:0]      mem_wdata_q, rsp_rdata_q, load_data;
   logic [1:0]       rsp_err_q;

   lsu_align_check u_align (
      .size       (bus.req_size),
      .addr_lo    (bus.req_addr[1:0]),
      .misaligned (misaligned)
   );

   always_comb begin
      accept    = (state_q == ST_IDLE) && bus.req_valid;
      mem_done  = (state_q == ST_WAIT) && bus.mem_ready;
      // mem_ready on the final counted edge takes priority over the timeout.
      timed_out = (state_q == ST_WAIT) && !bus.mem_ready &&
                  (TIMEOUT != 0) && (cnt_q == TO_LAST);
   end

`ifdef LSU_UNSIGNED_EN
   logic uns_q;
   always_comb load_data = uns_q ? zext_load(mem_sel_q, bus.mem_rdata) : bus.mem_rdata;
`else
   always_comb load_data = bus.mem_rdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = misaligned ? ST_RESP : ST_WAIT;
         ST_WAIT: if (mem_done || timed_out) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_byte_addr_q <= '0;
         mem_sel_q       <= '0;
         mem_wdata_q     <= '0;
         rsp_rdata_q     <= '0;
         rsp_err_q       <= ERR_OK;
         cnt_q           <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         if (misaligned) begin
            rsp_err_q   <= ERR_MISALIGN;
            rsp_rdata_q <= '0;
         end else begin
            mem_req_q       <= 1'b1;
            mem_we_q        <= bus.req_we;
            mem_addr_q      <= bus.req_addr[31:2];
            mem_byte_addr_q <= bus.req_addr[1:0];
            mem_sel_q       <= bus.req_size;
            mem_wdata_q     <= bus.req_wdata;
         end
      end else if (mem_done) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_err_q   <= ERR_OK;
         rsp_rdata_q <= mem_we_q ? 32'h0 : load_data;
      end else if (timed_out) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_err_q   <= ERR_TIMEOUT;
         rsp_rdata_q <= '0;
      end else if (state_q == ST_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef LSU_UNSIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      uns_q <= 1'b0;
      else if (accept && !misaligned)  uns_q <= bus.req_unsigned;
   end
`endif

   always_comb begin
      bus.req_ready     = (state_q == ST_IDLE);
      bus.busy          = (state_q != ST_IDLE);
      bus.rsp_valid     = (state_q == ST_RESP);
      bus.rsp_rdata     = rsp_rdata_q;
      bus.rsp_err       = rsp_err_q;
      bus.mem_req       = mem_req_q;
      bus.mem_we        = mem_we_q;
      bus.mem_addr      = mem_addr_q;
      bus.mem_byte_addr = mem_byte_addr_q;
      bus.mem_sel       = mem_sel_q;
      bus.mem_wdata     = mem_wdata_q;
      state_dbg         = state_q;
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port; the unsigned-load steps build only when
// LSU_UNSIGNED_EN is defined.
module tb_lsu_mem_port;
   import lsu_pkg::*;

   logic       clk;
   logic       rst_n;
   lsu_state_e state_dbg;
   int         n_cmp;
   int         n_err;

   lsu_mem_port_if bus ();

   lsu_mem_port #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.master),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, ".busy"},      32'(bus.busy),      32'd0);
      chk({tag, ".mem_req"},   32'(bus.mem_req),   32'd0);
   endtask

   // Plain load with mem_ready high: one WAIT cycle, response in cycle 2.
   task automatic load_fast(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp_rdata);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rdata;
      issue(1'b0, size, addr, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk({tag, ".c1.mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, ".c1.mem_we"},  32'(bus.mem_we),  32'd0);
      tick();
      chk({tag, ".c2.rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".c2.rsp_rdata"}, bus.rsp_rdata, exp_rdata);
      chk({tag, ".c2.rsp_err"},   32'(bus.rsp_err), 32'(ERR_OK));
      tick();
      chk_idle({tag, ".c3"});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = SZ_WORD;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
`ifdef LSU_UNSIGNED_EN
      bus.req_unsigned = 1'b0;
`endif
      bus.mem_rdata = 32'h0;
      bus.mem_ready = 1'b1;

      // reset values
      tick(); tick();
      chk_idle("rst");
      chk("rst.mem_we",        32'(bus.mem_we),        32'd0);
      chk("rst.mem_addr",      32'(bus.mem_addr),      32'd0);
      chk("rst.mem_byte_addr", 32'(bus.mem_byte_addr), 32'd0);
      chk("rst.mem_sel",       32'(bus.mem_sel),       32'd0);
      chk("rst.mem_wdata",     bus.mem_wdata,          32'd0);
      chk("rst.rsp_rdata",     bus.rsp_rdata,          32'd0);
      chk("rst.rsp_err",       32'(bus.rsp_err),       32'd0);
      chk("rst.state",         32'(state_dbg),         32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // word load at 0x4
      bus.mem_rdata = 32'h0ba00007;
      issue(1'b0, SZ_WORD, 32'h0000_0004, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("wl.c1.mem_req",       32'(bus.mem_req),       32'd1);
      chk("wl.c1.mem_we",        32'(bus.mem_we),        32'd0);
      chk("wl.c1.mem_addr",      32'(bus.mem_addr),      32'd1);
      chk("wl.c1.mem_byte_addr", 32'(bus.mem_byte_addr), 32'd0);
      chk("wl.c1.mem_sel",       32'(bus.mem_sel),       32'(SZ_WORD));
      chk("wl.c1.busy",          32'(bus.busy),          32'd1);
      chk("wl.c1.req_ready",     32'(bus.req_ready),     32'd0);
      chk("wl.c1.rsp_valid",     32'(bus.rsp_valid),     32'd0);
      tick();
      chk("wl.c2.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("wl.c2.rsp_rdata", bus.rsp_rdata,      32'h0ba00007);
      chk("wl.c2.rsp_err",   32'(bus.rsp_err),   32'(ERR_OK));
      chk("wl.c2.mem_req",   32'(bus.mem_req),   32'd0);
      tick();
      chk_idle("wl.c3");

      // byte store at 0x2; read data on the bus must not leak into the response
      bus.mem_rdata = 32'hDEAD_BEEF;
      issue(1'b1, SZ_BYTE, 32'h0000_0002, 32'h0000_00A5);
      tick();
      bus.req_valid = 1'b0;
      chk("bs.c1.mem_req",       32'(bus.mem_req),       32'd1);
      chk("bs.c1.mem_we",        32'(bus.mem_we),        32'd1);
      chk("bs.c1.mem_addr",      32'(bus.mem_addr),      32'd0);
      chk("bs.c1.mem_byte_addr", 32'(bus.mem_byte_addr), 32'd2);
      chk("bs.c1.mem_sel",       32'(bus.mem_sel),       32'(SZ_BYTE));
      chk("bs.c1.mem_wdata",     bus.mem_wdata,          32'h0000_00A5);
      tick();
      chk("bs.c2.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bs.c2.rsp_rdata", bus.rsp_rdata,      32'd0);
      chk("bs.c2.rsp_err",   32'(bus.rsp_err),   32'(ERR_OK));
      chk("bs.c2.mem_req",   32'(bus.mem_req),   32'd0);
      chk("bs.c2.mem_we",    32'(bus.mem_we),    32'd0);
      tick();
      chk_idle("bs.c3");

      // misaligned half store at 0x3: no memory access, error in cycle 1
      issue(1'b1, SZ_HALF, 32'h0000_0003, 32'h0000_1234);
      tick();
      bus.req_valid = 1'b0;
      chk("hm.c1.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hm.c1.rsp_err",   32'(bus.rsp_err),   32'(ERR_MISALIGN));
      chk("hm.c1.rsp_rdata", bus.rsp_rdata,      32'd0);
      chk("hm.c1.mem_req",   32'(bus.mem_req),   32'd0);
      chk("hm.c1.mem_we",    32'(bus.mem_we),    32'd0);
      tick();
      chk_idle("hm.c2");

      // misaligned word load at 0x2
      issue(1'b0, SZ_WORD, 32'h0000_0102, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("wm.c1.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("wm.c1.rsp_err",   32'(bus.rsp_err),   32'(ERR_MISALIGN));
      chk("wm.c1.mem_req",   32'(bus.mem_req),   32'd0);
      tick();

      // aligned half at 0x2 and bit at an odd address are accepted
      load_fast("ha", SZ_HALF, 32'h0000_0012, 32'hFFFF_8001, 32'hFFFF_8001);
      load_fast("bt", SZ_BIT,  32'h0000_0013, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // word load with mem_ready low for 3 edges; a different request stays
      // on req_valid while busy and must be ignored
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h1357_9BDF;
      issue(1'b0, SZ_WORD, 32'h0000_0040, 32'h0);
      tick();
      issue(1'b1, SZ_BYTE, 32'h0000_0101, 32'hFFFF_FFFF);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ws.c%0d.mem_req", i),  32'(bus.mem_req),   32'd1);
         chk($sformatf("ws.c%0d.mem_addr", i), 32'(bus.mem_addr),  32'h10);
         chk($sformatf("ws.c%0d.mem_we", i),   32'(bus.mem_we),    32'd0);
         chk($sformatf("ws.c%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
         if (i == 4) bus.mem_ready = 1'b1;
         tick();
      end
      bus.req_valid = 1'b0;
      chk("ws.c5.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ws.c5.rsp_rdata", bus.rsp_rdata,      32'h1357_9BDF);
      chk("ws.c5.rsp_err",   32'(bus.rsp_err),   32'(ERR_OK));
      tick();
      chk_idle("ws.c6");

      // mem_ready stuck low: timeout after 16 WAIT cycles
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hCAFE_F00D;
      issue(1'b0, SZ_WORD, 32'h0000_0080, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("to.c%0d.mem_req", i),   32'(bus.mem_req),   32'd1);
         chk($sformatf("to.c%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
         tick();
      end
      chk("to.c17.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("to.c17.rsp_err",   32'(bus.rsp_err),   32'(ERR_TIMEOUT));
      chk("to.c17.rsp_rdata", bus.rsp_rdata,      32'd0);
      chk("to.c17.mem_req",   32'(bus.mem_req),   32'd0);
      tick();
      chk_idle("to.c18");

      // mem_ready arrives on the 16th WAIT edge: completion beats timeout
      issue(1'b0, SZ_WORD, 32'h0000_00C0, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 15; i++) tick();
      chk("tr.c16.mem_req", 32'(bus.mem_req), 32'd1);
      bus.mem_ready = 1'b1;
      tick();
      chk("tr.c17.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tr.c17.rsp_err",   32'(bus.rsp_err),   32'(ERR_OK));
      chk("tr.c17.rsp_rdata", bus.rsp_rdata,      32'hCAFE_F00D);
      tick();

      // reset asserted mid-store while waiting
      bus.mem_ready = 1'b0;
      issue(1'b1, SZ_WORD, 32'h0000_0100, 32'h5555_AAAA);
      tick();
      bus.req_valid = 1'b0;
      tick();
      chk("ra.pre.mem_we", 32'(bus.mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ra.mem_req", 32'(bus.mem_req),  32'd0);
      chk("ra.mem_we",  32'(bus.mem_we),   32'd0);
      chk("ra.state",   32'(state_dbg),    32'(ST_IDLE));
      tick();
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ra.p%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
         tick();
      end
      load_fast("rb", SZ_WORD, 32'h0000_0200, 32'h8765_4321, 32'h8765_4321);

`ifdef LSU_UNSIGNED_EN
      bus.req_unsigned = 1'b1;
      load_fast("ub", SZ_BYTE, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0000_00F0);
      load_fast("uh", SZ_HALF, 32'h0000_0002, 32'hFFFF_8001, 32'h0000_8001);
      load_fast("ui", SZ_BIT,  32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001);
      load_fast("uw", SZ_WORD, 32'h0000_0004, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
      bus.req_unsigned = 1'b0;
      load_fast("sb", SZ_BYTE, 32'h0000_0001, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
